// File: rtl/aline_echo_capture.sv
// Echo capture buffer for one A-line, then framed UART readout.
// Ports: afe_switch/adc_* capture in, tx_* UART out, mem_clear/overrun status.
module aline_echo_capture #(
  parameter int          ADC_WIDTH    = 10,
  parameter int          NUM_SAMPLES  = 256,
  parameter int          ADDR_WIDTH   = 8,
  parameter logic [7:0]  FRAME_HEADER = 8'hA5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 afe_switch,
  input  logic [3:0]           current_aline,
  input  logic [ADC_WIDTH-1:0] adc_data,
  input  logic                 adc_valid,
  input  logic                 tx_ready,
  output logic [7:0]           tx_data,
  output logic                 tx_start,
  output logic                 mem_clear,
  output logic                 capture_in_progress,
  output logic                 overrun
);

  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] FULL = CW'(NUM_SAMPLES);

  typedef enum logic [3:0] {
    IDLE, CAPTURE, HEADER, ALINE, CNT_HI,
    CNT_LO, S_HI, S_LO, WAIT_BUSY, DONE
  } state_t;

  state_t state, state_n;
  state_t ret, ret_n;

  logic                  afe_d;
  logic                  rise, fall;
  logic [3:0]            aline_q, aline_n;
  logic [ADDR_WIDTH-1:0] wr_ptr, wr_n;
  logic [ADDR_WIDTH-1:0] rd_ptr, rd_n;
  logic [CW-1:0]         sample_count, cnt_n;
  logic [7:0]            tx_data_n;
  logic                  tx_start_n;
  logic                  mem_clear_n;
  logic                  overrun_n;
  logic                  we;
  logic                  last;
  logic [7:0]            byte_sel;
  logic [15:0]           cnt16, smp16;

  logic [ADC_WIDTH-1:0]  mem [NUM_SAMPLES];
  logic [ADC_WIDTH-1:0]  ram_q;

  // Tracks the pin even in reset so reset release never fakes a rise.
  always_ff @(posedge clk) afe_d <= afe_switch;

  assign rise = afe_switch & ~afe_d;
  assign fall = ~afe_switch & afe_d;
  assign capture_in_progress = (state == CAPTURE);

  // Read port runs every cycle; rd_ptr settles long before S_HI needs it.
  always_ff @(posedge clk) begin
    if (we) mem[wr_ptr] <= adc_data;
    ram_q <= mem[rd_ptr];
  end

  assign cnt16 = 16'(sample_count);
  assign smp16 = 16'(ram_q);
  assign last  = ({1'b0, rd_ptr} + 1'b1) == sample_count;

  always_comb begin
    byte_sel = 8'h00;
    unique case (state)
      HEADER:  byte_sel = FRAME_HEADER;
      ALINE:   byte_sel = {4'b0, aline_q};
      CNT_HI:  byte_sel = cnt16[15:8];
      CNT_LO:  byte_sel = cnt16[7:0];
      S_HI:    byte_sel = smp16[15:8];
      S_LO:    byte_sel = smp16[7:0];
      default: byte_sel = 8'h00;
    endcase
  end

  always_comb begin
    state_n     = state;
    ret_n       = ret;
    aline_n     = aline_q;
    wr_n        = wr_ptr;
    rd_n        = rd_ptr;
    cnt_n       = sample_count;
    tx_data_n   = tx_data;
    tx_start_n  = 1'b0;
    mem_clear_n = mem_clear;
    overrun_n   = rise && (state != IDLE);
    we          = 1'b0;
    unique case (state)
      IDLE: begin
        if (rise) begin
          aline_n     = current_aline;
          wr_n        = '0;
          rd_n        = '0;
          cnt_n       = '0;
          mem_clear_n = 1'b0;
          state_n     = CAPTURE;
        end
      end
      CAPTURE: begin
        if (adc_valid && sample_count != FULL) begin
          we    = 1'b1;
          wr_n  = wr_ptr + 1'b1;
          cnt_n = sample_count + 1'b1;
        end
        if (fall || cnt_n == FULL) state_n = HEADER;
      end
      HEADER, ALINE, CNT_HI, CNT_LO, S_HI, S_LO: begin
        if (tx_ready) begin
          tx_start_n = 1'b1;
          tx_data_n  = byte_sel;
          state_n    = WAIT_BUSY;
          unique case (state)
            HEADER: ret_n = ALINE;
            ALINE:  ret_n = CNT_HI;
            CNT_HI: ret_n = CNT_LO;
            CNT_LO: ret_n = (sample_count == '0) ? DONE : S_HI;
            S_HI:   ret_n = S_LO;
            default: begin
              ret_n = last ? DONE : S_HI;
              rd_n  = rd_ptr + 1'b1;
            end
          endcase
        end
      end
      WAIT_BUSY: begin
        if (!tx_ready) state_n = ret;
      end
      DONE: begin
        mem_clear_n = 1'b1;
        state_n     = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      ret          <= IDLE;
      aline_q      <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      sample_count <= '0;
      tx_data      <= '0;
      tx_start     <= 1'b0;
      mem_clear    <= 1'b1;
      overrun      <= 1'b0;
    end else begin
      state        <= state_n;
      ret          <= ret_n;
      aline_q      <= aline_n;
      wr_ptr       <= wr_n;
      rd_ptr       <= rd_n;
      sample_count <= cnt_n;
      tx_data      <= tx_data_n;
      tx_start     <= tx_start_n;
      mem_clear    <= mem_clear_n;
      overrun      <= overrun_n;
    end
  end

endmodule

// File: tb/tb_aline_echo_capture.sv
// Bench for aline_echo_capture: UART model plus packet-level reference.
// Expected packets are built from the samples the bench itself feeds.
module tb_aline_echo_capture;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       afe_switch = 1'b0;
  logic [3:0] current_aline = 4'd0;
  logic [9:0] adc_data = 10'd0;
  logic       adc_valid = 1'b0;
  logic       tx_ready = 1'b1;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       mem_clear;
  logic       capture_in_progress;
  logic       overrun;

  aline_echo_capture dut (
    .clk                 (clk),
    .rst                 (rst),
    .afe_switch          (afe_switch),
    .current_aline       (current_aline),
    .adc_data            (adc_data),
    .adc_valid           (adc_valid),
    .tx_ready            (tx_ready),
    .tx_data             (tx_data),
    .tx_start            (tx_start),
    .mem_clear           (mem_clear),
    .capture_in_progress (capture_in_progress),
    .overrun             (overrun)
  );

  always #5 clk = ~clk;

  int         n_cmp = 0;
  int         n_fail = 0;
  int         ovr_cnt = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got[$];
  int         samp[$];
  bit         pkt_active = 0;
  bit         hold_low = 0;
  bit         uart_idle = 1;
  bit         start_d = 0;
  bit         ready_prev = 1;
  int         busy = 0;

  task automatic chk(string nm, int act, int req);
    n_cmp++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  // One cycle: observe DUT at negedge, run UART model, drive tx_ready.
  task automatic step();
    @(negedge clk);
    if (tx_start) begin
      chk("start_only_when_ready", ready_prev, 1);
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_byte: got %0h expected none", tx_data);
      end else begin
        chk("packet_byte", tx_data, exp_q[0]);
        void'(exp_q.pop_front());
      end
      got.push_back(tx_data);
    end
    if (overrun) ovr_cnt++;
    if (pkt_active) chk("mem_clear_low", mem_clear, 0);
    if (start_d) begin
      uart_idle = 0;
      busy = 3;
    end else if (busy > 0) begin
      busy--;
      if (busy == 0) uart_idle = 1;
    end
    start_d = tx_start;
    tx_ready = uart_idle && !hold_low;
    ready_prev = tx_ready;
  endtask

  task automatic set_hold(bit v);
    hold_low = v;
    tx_ready = uart_idle && !hold_low;
    ready_prev = tx_ready;
  endtask

  task automatic run_aline(logic [3:0] al, bit gaps, bit disturb);
    int n;
    int v;
    int g;
    n = (samp.size() > 256) ? 256 : samp.size();
    got.delete();
    exp_q.delete();
    exp_q.push_back(8'hA5);
    exp_q.push_back({4'b0, al});
    exp_q.push_back(8'((n >> 8) & 255));
    exp_q.push_back(8'(n & 255));
    for (int i = 0; i < n; i++) begin
      v = samp[i] & 10'h3FF;
      exp_q.push_back(8'(v >> 8));
      exp_q.push_back(8'(v & 255));
    end
    current_aline = al;
    afe_switch = 1'b1;
    step();
    pkt_active = 1;
    chk("cip_after_rise", capture_in_progress, 1);
    foreach (samp[i]) begin
      adc_data = 10'(samp[i]);
      adc_valid = 1'b1;
      step();
      adc_valid = 1'b0;
      if (gaps) step();
    end
    afe_switch = 1'b0;
    step();
    chk("cip_after_fall", capture_in_progress, 0);
    if (disturb) begin
      g = 0;
      while (got.size() < 3 && g < 2000) begin
        step();
        g++;
      end
      chk("disturb_reached", got.size() >= 3, 1);
      set_hold(1);
      afe_switch = 1'b1;
      step();
      afe_switch = 1'b0;
      for (int i = 0; i < 49; i++) step();
      set_hold(0);
    end
    g = 0;
    while (exp_q.size() > 0 && g < 20000) begin
      step();
      g++;
    end
    chk("packet_complete", exp_q.size(), 0);
    pkt_active = 0;
    g = 0;
    while (!mem_clear && g < 10) begin
      step();
      g++;
    end
    chk("mem_clear_done", mem_clear, 1);
    for (int i = 0; i < 10; i++) step();
    chk("byte_total", got.size(), 4 + 2 * n);
  endtask

  initial begin
    repeat (3) step();
    rst = 1'b0;
    step();
    chk("rst_mem_clear", mem_clear, 1);
    chk("rst_tx_start", tx_start, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_cip", capture_in_progress, 0);

    repeat (20) step();
    chk("idle_no_bytes", got.size(), 0);
    chk("idle_mem_clear", mem_clear, 1);
    chk("idle_overrun", ovr_cnt, 0);

    // Full buffer, plus one extra sample that must be dropped.
    samp.delete();
    for (int i = 0; i < 256; i++) samp.push_back(i);
    samp.push_back(10'h155);
    run_aline(4'd3, 0, 0);
    if (got.size() == 516) begin
      chk("full_b0", got[0], 8'hA5);
      chk("full_b1", got[1], 8'h03);
      chk("full_b2", got[2], 8'h01);
      chk("full_b3", got[3], 8'h00);
      chk("full_b5", got[5], 8'h00);
      chk("full_b7", got[7], 8'h01);
      chk("full_b514", got[514], 8'h00);
      chk("full_b515", got[515], 8'hFF);
    end

    samp.delete();
    repeat (5) samp.push_back(10'h3FF);
    run_aline(4'd7, 1, 0);
    if (got.size() == 14) begin
      chk("max_cnt_lo", got[3], 8'h05);
      chk("max_s_hi", got[4], 8'h03);
      chk("max_s_lo", got[13], 8'hFF);
    end

    samp.delete();
    run_aline(4'd12, 0, 0);
    if (got.size() == 4) begin
      chk("empty_aline", got[1], 8'h0C);
      chk("empty_cnt", got[3], 8'h00);
    end

    ovr_cnt = 0;
    samp.delete();
    samp.push_back(10'h2A5);
    samp.push_back(10'h15A);
    samp.push_back(10'h001);
    samp.push_back(10'h100);
    samp.push_back(10'h3C3);
    run_aline(4'd5, 0, 1);
    chk("overrun_once", ovr_cnt, 1);
    if (got.size() == 14) chk("hold_s0_hi", got[4], 8'h02);

    // Abort a capture with reset, then capture a fresh line.
    ovr_cnt = 0;
    current_aline = 4'd9;
    afe_switch = 1'b1;
    step();
    for (int i = 0; i < 100; i++) begin
      adc_data = 10'(i + 50);
      adc_valid = 1'b1;
      step();
    end
    adc_valid = 1'b0;
    afe_switch = 1'b0;
    rst = 1'b1;
    step();
    chk("abort_mem_clear", mem_clear, 1);
    chk("abort_cip", capture_in_progress, 0);
    rst = 1'b0;
    repeat (5) step();
    samp.delete();
    samp.push_back(10'h0AB);
    samp.push_back(10'h2CD);
    samp.push_back(10'h3EF);
    run_aline(4'd4, 0, 0);
    if (got.size() == 10) chk("fresh_cnt", got[3], 8'h03);
    chk("no_overrun_after_abort", ovr_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/aline_echo_capture.md
Name: aline_echo_capture

Overview:
- Downstream neighbour of the image transmit FSM: captures the echo samples of one A-line while the AFE switch is in receive position, buffers them, then streams a framed packet out through the UART transmitter.
- Drives `mem_clear` back to the transmit FSM, which waits on it before starting the next A-line.
- `mem_clear` high means the buffer is drained and the next pulse may fire.

Parameters:
- ADC_WIDTH, 10, sample width in bits (1..16).
- NUM_SAMPLES, 256, maximum samples per A-line (power of 2, ≤ 65535).
- ADDR_WIDTH, 8, log2(NUM_SAMPLES).
- FRAME_HEADER, 8'hA5, first byte of every packet.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- afe_switch  in  1  AFE receive window (from aline transmit path); rising edge starts capture, falling edge ends window.
- current_aline  in  4  A-line index from image transmit FSM; sampled at capture start.
- adc_data  in  ADC_WIDTH  echo sample.
- adc_valid  in  1  adc_data valid this cycle.
- tx_ready  in  1  UART transmitter idle.
- tx_data  out  8  byte to UART.
- tx_start  out  1  one-cycle pulse: load tx_data into UART.
- mem_clear  out  1  buffer empty / packet fully sent.
- capture_in_progress  out  1  high in CAPTURE.
- overrun  out  1  one-cycle pulse: afe_switch rising edge while not IDLE.

Behaviour:
- Reset values: tx_data=0, tx_start=0, mem_clear=1, capture_in_progress=0, overrun=0, state=IDLE, wr_ptr=0, rd_ptr=0, sample_count=0.
- afe_switch is registered once. rise = afe_switch & ~afe_switch_d; fall = ~afe_switch & afe_switch_d. All logic is posedge clk.
- Buffer: NUM_SAMPLES x ADC_WIDTH single-port RAM, written in CAPTURE and read in SEND. RAM read has 1-cycle latency.
- IDLE:
  - On rise: latch current_aline, wr_ptr<=0, mem_clear<=0, go to CAPTURE.
  - A sample with adc_valid in the same cycle as rise is not stored.
- CAPTURE (capture_in_progress=1):
  - Each adc_valid cycle writes adc_data at wr_ptr and increments sample_count.
  - Leaves for HEADER when sample_count reaches NUM_SAMPLES, or on fall, whichever comes first.
  - If both happen in the same cycle and adc_valid is high, that sample is stored first.
  - Samples arriving after NUM_SAMPLES are dropped.
- Send states: HEADER, ALINE, CNT_HI, CNT_LO, then per sample S_HI, S_LO.
  - Each byte: wait for tx_ready=1, then drive tx_data and pulse tx_start for 1 cycle.
  - Then WAIT_BUSY: until tx_ready=0. The UART deasserts tx_ready the cycle after tx_start.
  - Then advance to the next byte.
- Byte contents:
  - HEADER: FRAME_HEADER.
  - ALINE: {4'b0, latched aline}.
  - CNT_HI / CNT_LO: sample_count[15:8] / [7:0], zero-extended.
  - S_HI: sample zero-extended to 16 bits, bits [15:8].
  - S_LO: bits [7:0].
  - Samples are sent in write order, rd_ptr 0..sample_count-1.
- sample_count=0 (fall before any valid sample): send 4-byte frame with count 0, no sample bytes.
- After the last byte's WAIT_BUSY, go to DONE. DONE: mem_clear<=1, go to IDLE. Total packet = 4 + 2*sample_count bytes.
- rise while not IDLE: ignored for capture, overrun pulses 1 cycle, current packet continues unchanged.
- afe_switch activity during send states: no effect other than overrun on rise.
- rst mid-capture or mid-send: immediately back to reset values. Any UART byte already started completes on its own, and no further tx_start is issued.
- mem_clear is low continuously from the cycle after rise (in IDLE) to DONE.

Test Plan:
- Reset, then hold afe_switch=0 and tx_ready=1 for 20 cycles -> mem_clear=1, tx_start never pulses, overrun=0.
- current_aline=3, rise, 256 valid samples 0..255 (ADC_WIDTH=10), fall after → 516 bytes: A5, 03, 01, 00, 00, 00, 00, 01, … 00, FF; mem_clear returns 1 one cycle after the last WAIT_BUSY.
- rise, 5 valid samples 10'h3FF, then fall → bytes A5, aline, 00, 05, then 5×(03, FF); no extra bytes.
- rise then fall with adc_valid=0 → exactly 4 bytes A5, aline, 00, 00; mem_clear=1 afterwards.
- tx_ready held low 50 cycles mid-packet → no tx_start until tx_ready=1, no bytes lost or duplicated; second rise during send → overrun pulses once, packet unchanged.
- rst asserted during CAPTURE after 100 samples → next cycle mem_clear=1, capture_in_progress=0; a following rise captures a fresh A-line with count starting at 0.
